// File: rtl/cosmac_bus_ctrl.sv
// cosmac_bus_ctrl: COSMAC pin front end -- XCLK/CLEAR generation, pin synchronizers,
// MRD/MWR to single-cycle memory requests. Define COSMEM_WAIT_EN to stall the CPU on reads.
module cosmac_bus_ctrl #(
  parameter int XCLK_DIV   = 4,
  parameter int CLR_CYCLES = 16,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic              xclk,
  output logic              nclear,
  output logic              nwait,
  input  logic              tpa,
  input  logic              tpb,
  input  logic              nmrd,
  input  logic              nmwr,
  input  logic [7:0]        ma,
  input  logic [7:0]        db_in,
  output logic [7:0]        db_out,
  output logic              db_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  output logic              bus_err
);
  localparam int DIV_W = $clog2(XCLK_DIV);
  localparam int CLR_W = $clog2(CLR_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_REQ   = 3'd1,
    RD_WAIT  = 3'd2,
    RD_DRIVE = 3'd3,
    WR_CAPT  = 3'd4
  } state_t;

  // Strobe shift registers: [0],[1] synchronize, [2] is the edge-detect reference.
  logic [2:0] tpa_sr_q, nmrd_sr_q, nmwr_sr_q;
  logic [1:0] tpb_sr_q;
  logic [7:0] ma_s1_q, ma_s2_q, db_s1_q, db_s2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tpa_sr_q  <= 3'b000;
      tpb_sr_q  <= 2'b00;
      nmrd_sr_q <= 3'b111;
      nmwr_sr_q <= 3'b111;
      ma_s1_q   <= 8'h00;
      ma_s2_q   <= 8'h00;
      db_s1_q   <= 8'h00;
      db_s2_q   <= 8'h00;
    end else begin
      tpa_sr_q  <= {tpa_sr_q[1:0], tpa};
      tpb_sr_q  <= {tpb_sr_q[0], tpb};
      nmrd_sr_q <= {nmrd_sr_q[1:0], nmrd};
      nmwr_sr_q <= {nmwr_sr_q[1:0], nmwr};
      ma_s1_q   <= ma;
      ma_s2_q   <= ma_s1_q;
      db_s1_q   <= db_in;
      db_s2_q   <= db_s1_q;
    end
  end

  logic nmrd_s, nmwr_s, tpa_fall, nmrd_fall, nmwr_fall;
  assign nmrd_s    = nmrd_sr_q[1];
  assign nmwr_s    = nmwr_sr_q[1];
  assign tpa_fall  = tpa_sr_q[2] & ~tpa_sr_q[1];
  assign nmrd_fall = nmrd_sr_q[2] & ~nmrd_sr_q[1];
  assign nmwr_fall = nmwr_sr_q[2] & ~nmwr_sr_q[1];

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [CLR_W-1:0]    clr_cnt_q, clr_cnt_d;
  logic                xclk_q, xclk_d, nclear_q, nclear_d, xclk_rise;
  logic [7:0]          addr_hi_q, addr_hi_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_rd_q, mem_rd_d, mem_we_q, mem_we_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d, db_out_q, db_out_d;
  logic                db_oe_q, db_oe_d, bus_err_q, bus_err_d;
`ifdef COSMEM_WAIT_EN
  logic                nwait_q, nwait_d;
`endif

  logic [15:0]       full_addr;
  logic [ADDR_W-1:0] eff_addr;
  assign full_addr = {addr_hi_q, ma_s2_q};
  assign eff_addr  = full_addr[ADDR_W-1:0];

  // TPB is synchronized for completeness but nothing in this block consumes it.
  logic unused_tpb;
  assign unused_tpb = tpb_sr_q[1];
  if (ADDR_W < 16) begin : g_unused_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^full_addr[15:ADDR_W];
  end

  always_comb begin
    div_d     = div_q + 1'b1;
    xclk_d    = xclk_q;
    xclk_rise = 1'b0;
    if (div_q == DIV_W'(XCLK_DIV - 1)) begin
      div_d     = '0;
      xclk_d    = ~xclk_q;
      xclk_rise = ~xclk_q;
    end
    clr_cnt_d = clr_cnt_q;
    if (xclk_rise && (clr_cnt_q != CLR_W'(CLR_CYCLES)))
      clr_cnt_d = clr_cnt_q + 1'b1;
    nclear_d  = nclear_q | (clr_cnt_q == CLR_W'(CLR_CYCLES));
    addr_hi_d = tpa_fall ? ma_s2_q : addr_hi_q;
    bus_err_d = bus_err_q | (~nmrd_s & ~nmwr_s);
  end

  always_comb begin
    state_d     = state_q;
    mem_rd_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    db_out_d    = db_out_q;
    db_oe_d     = db_oe_q;
`ifdef COSMEM_WAIT_EN
    nwait_d     = nwait_q;
`endif
    case (state_q)
      IDLE: begin
        if (nmrd_fall) begin
          state_d = RD_REQ;
`ifdef COSMEM_WAIT_EN
          nwait_d = 1'b0;
`endif
        end else if (nmwr_fall) begin
          state_d     = WR_CAPT;
          mem_wdata_d = db_s2_q;
          mem_addr_d  = eff_addr;
        end
      end
      RD_REQ: begin
        mem_rd_d   = 1'b1;
        mem_addr_d = eff_addr;
        state_d    = RD_WAIT;
      end
      RD_WAIT: begin
        // MRD released before data arrived: the read is dropped, never driven.
        if (nmrd_s) begin
          state_d = IDLE;
`ifdef COSMEM_WAIT_EN
          nwait_d = 1'b1;
`endif
        end else if (mem_rvalid) begin
          db_out_d = mem_rdata;
          db_oe_d  = 1'b1;
          state_d  = RD_DRIVE;
`ifdef COSMEM_WAIT_EN
          nwait_d  = 1'b1;
`endif
        end
      end
      RD_DRIVE: begin
        if (nmrd_s) begin
          db_oe_d = 1'b0;
          state_d = IDLE;
        end
      end
      WR_CAPT: begin
        if (nmrd_fall) begin
          state_d = RD_REQ;
`ifdef COSMEM_WAIT_EN
          nwait_d = 1'b0;
`endif
        end else if (!nmwr_s) begin
          mem_wdata_d = db_s2_q;
          mem_addr_d  = eff_addr;
        end else begin
          // A write overlapping an active read strobe is never committed.
          mem_we_d = nmrd_s;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      div_q       <= '0;
      clr_cnt_q   <= '0;
      xclk_q      <= 1'b0;
      nclear_q    <= 1'b0;
      addr_hi_q   <= 8'h00;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 8'h00;
      db_out_q    <= 8'h00;
      db_oe_q     <= 1'b0;
      bus_err_q   <= 1'b0;
`ifdef COSMEM_WAIT_EN
      nwait_q     <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      clr_cnt_q   <= clr_cnt_d;
      xclk_q      <= xclk_d;
      nclear_q    <= nclear_d;
      addr_hi_q   <= addr_hi_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      db_out_q    <= db_out_d;
      db_oe_q     <= db_oe_d;
      bus_err_q   <= bus_err_d;
`ifdef COSMEM_WAIT_EN
      nwait_q     <= nwait_d;
`endif
    end
  end

`ifdef COSMEM_WAIT_EN
  assign nwait = nwait_q;
`else
  assign nwait = 1'b1;
`endif
  assign xclk      = xclk_q;
  assign nclear    = nclear_q;
  assign db_out    = db_out_q;
  assign db_oe     = db_oe_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign bus_err   = bus_err_q;
endmodule

// File: tb/tb_cosmac_bus_ctrl.sv
// Directed-vector bench for cosmac_bus_ctrl: clock/clear timing, reads, writes,
// bus error, abandoned reads, slow memory and asynchronous reset mid-transfer.
module tb_cosmac_bus_ctrl;
  logic       clk = 1'b0, reset = 1'b1;
  logic       xclk, nclear, nwait, tpa, tpb, nmrd, nmwr;
  logic [7:0] ma, db_in, db_out, mem_rdata, mem_wdata;
  logic       db_oe, mem_rd, mem_rvalid, mem_we, bus_err;
  logic [7:0] mem_addr;

  cosmac_bus_ctrl #(.XCLK_DIV(4), .CLR_CYCLES(16), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .xclk(xclk), .nclear(nclear), .nwait(nwait),
    .tpa(tpa), .tpb(tpb), .nmrd(nmrd), .nmwr(nmwr), .ma(ma), .db_in(db_in),
    .db_out(db_out), .db_oe(db_oe), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

`ifdef COSMEM_WAIT_EN
  localparam logic WAIT_LOW = 1'b0;
`else
  localparam logic WAIT_LOW = 1'b1;
`endif

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Memory model and bus monitor, sampled on the falling edge.
  logic [7:0] mem [256];
  int         lat = 1, pend = 0;
  logic [7:0] pend_addr;
  int         rd_cnt = 0, we_cnt = 0;
  logic [7:0] rd_addr_last = 8'h00, we_addr = 8'h00, we_data = 8'h00;
  logic       both_seen = 1'b0, oe_seen = 1'b0, nwait_low_seen = 1'b0;

  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    if (reset) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem[pend_addr];
        end
      end
      if (mem_rd) begin
        rd_cnt++;
        rd_addr_last = mem_addr;
        pend_addr    = mem_addr;
        pend         = lat;
      end
      if (mem_we) begin
        we_cnt++;
        we_addr = mem_addr;
        we_data = mem_wdata;
        mem[mem_addr] = mem_wdata;
      end
      if (mem_rd && mem_we) both_seen = 1'b1;
      if (db_oe) oe_seen = 1'b1;
      if (!nwait) nwait_low_seen = 1'b1;
    end
  end

  task automatic cpu_read(input logic [7:0] a, input int hold, output logic [7:0] got,
                          output int lat_seen, output logic [2:0] oe_seq, output logic [63:0] nw);
    ma = a;
    nmrd = 1'b0;
    lat_seen = 0;
    nw = '1;
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      if (mem_rd && lat_seen == 0) lat_seen = i;
      if (i < 64) nw[i] = nwait;
    end
    got = db_out;
    nmrd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      oe_seq[2-i] = db_oe;
    end
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d0, input logic [7:0] d1, input int hold);
    ma = a;
    db_in = d0;
    nmwr = 1'b0;
    repeat (hold - 4) @(negedge clk);
    db_in = d1;
    repeat (4) @(negedge clk);
    nmwr = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  logic [7:0]  got;
  int          lseen, rd0, we0;
  logic [2:0]  oes;
  logic [63:0] nw;
  logic        exp_x, prev_x;
  int          rises;

  initial begin
    tpa = 0; tpb = 0; nmrd = 1; nmwr = 1; ma = 8'h00; db_in = 8'h00;
    mem_rdata = 8'h00; mem_rvalid = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_xclk", 32'(xclk), 32'd0);
    chk("rst_nclear", 32'(nclear), 32'd0);
    chk("rst_nwait", 32'(nwait), 32'd1);
    chk("rst_db_out", 32'(db_out), 32'd0);
    chk("rst_db_oe", 32'(db_oe), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);

    // XCLK period 8 clk; nclear rises the clk after the 16th xclk rising edge
    reset = 1'b0;
    rises = 0;
    prev_x = 1'b0;
    for (int n = 1; n <= 140; n++) begin
      @(negedge clk);
      exp_x = ((n / 4) % 2) == 1;
      chk("xclk", 32'(xclk), 32'(exp_x));
      chk("nclear", 32'(nclear), 32'(rises >= 16));
      if (exp_x && !prev_x) rises++;
      prev_x = exp_x;
    end
    chk("idle_nwait", 32'(nwait_low_seen), 32'd0);
    chk("idle_db_oe", 32'(oe_seen), 32'd0);

    // TPA latches high byte, then read of 0x05 with 1-cycle memory
    ma = 8'h00; tpa = 1'b1;
    repeat (4) @(negedge clk);
    tpa = 1'b0;
    repeat (4) @(negedge clk);
    rd0 = rd_cnt;
    cpu_read(8'h05, 40, got, lseen, oes, nw);
    chk("rd_count", 32'(rd_cnt - rd0), 32'd1);
    chk("rd_addr", 32'(rd_addr_last), 32'h05);
    chk("rd_data", 32'(got), 32'h05);
    chk("rd_latency", 32'(lseen), 32'd4);
    chk("rd_oe_release", 32'(oes), 32'b110);

    // Back-to-back reads 0..7
    rd0 = rd_cnt; we0 = we_cnt;
    for (int i = 0; i < 8; i++) begin
      cpu_read(8'(i), 16, got, lseen, oes, nw);
      chk("b2b_data", 32'(got), 32'(i));
      chk("b2b_addr", 32'(rd_addr_last), 32'(i));
    end
    chk("b2b_rd_count", 32'(rd_cnt - rd0), 32'd8);
    chk("b2b_no_we", 32'(we_cnt - we0), 32'd0);

    // Writes: single data value, then data changing during the strobe
    we0 = we_cnt; oe_seen = 1'b0;
    cpu_write(8'h03, 8'hA7, 8'hA7, 24);
    chk("wr_count", 32'(we_cnt - we0), 32'd1);
    chk("wr_addr", 32'(we_addr), 32'h03);
    chk("wr_data", 32'(we_data), 32'hA7);
    chk("wr_no_oe", 32'(oe_seen), 32'd0);
    cpu_write(8'h09, 8'h11, 8'h5C, 20);
    chk("wr2_count", 32'(we_cnt - we0), 32'd2);
    chk("wr2_addr", 32'(we_addr), 32'h09);
    chk("wr2_last_data", 32'(we_data), 32'h5C);
    cpu_read(8'h03, 16, got, lseen, oes, nw);
    chk("wr_readback", 32'(got), 32'hA7);

    // MRD and MWR low together
    chk("err_clear", 32'(bus_err), 32'd0);
    we0 = we_cnt; rd0 = rd_cnt;
    ma = 8'h02; nmrd = 1'b0; nmwr = 1'b0;
    repeat (16) @(negedge clk);
    got = db_out;
    nmrd = 1'b1; nmwr = 1'b1;
    repeat (8) @(negedge clk);
    chk("err_set", 32'(bus_err), 32'd1);
    chk("err_rd_data", 32'(got), 32'h02);
    chk("err_rd_count", 32'(rd_cnt - rd0), 32'd1);
    chk("err_no_we", 32'(we_cnt - we0), 32'd0);
    cpu_read(8'h06, 16, got, lseen, oes, nw);
    chk("err_sticky", 32'(bus_err), 32'd1);
    chk("err_next_rd", 32'(got), 32'h06);

    // Abandoned read: MRD released before slow data returns
    lat = 10; oe_seen = 1'b0; rd0 = rd_cnt;
    ma = 8'h04; nmrd = 1'b0;
    repeat (6) @(negedge clk);
    nmrd = 1'b1;
    repeat (20) @(negedge clk);
    chk("abn_rd_count", 32'(rd_cnt - rd0), 32'd1);
    chk("abn_no_oe", 32'(oe_seen), 32'd0);
    chk("abn_nwait", 32'(nwait), 32'd1);

    // Slow memory: WAIT from RD_REQ entry through the cycle of rvalid
    cpu_read(8'h07, 30, got, lseen, oes, nw);
    chk("slow_data", 32'(got), 32'h07);
    chk("slow_nw_pre", 32'(nw[2]), 32'd1);
    chk("slow_nw_req", 32'(nw[3]), 32'(WAIT_LOW));
    chk("slow_nw_rvalid", 32'(nw[14]), 32'(WAIT_LOW));
    chk("slow_nw_after", 32'(nw[15]), 32'd1);

    // Reset during RD_WAIT
    we0 = we_cnt;
    ma = 8'h06; nmrd = 1'b0;
    repeat (8) @(negedge clk);
    chk("rw_nwait_pre", 32'(nwait), 32'(WAIT_LOW));
    #2 reset = 1'b1;
    #1;
    chk("rw_nwait", 32'(nwait), 32'd1);
    chk("rw_db_oe", 32'(db_oe), 32'd0);
    chk("rw_bus_err", 32'(bus_err), 32'd0);
    chk("rw_nclear", 32'(nclear), 32'd0);
    nmrd = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    oe_seen = 1'b0;
    repeat (20) @(negedge clk);
    chk("rw_no_oe_after", 32'(oe_seen), 32'd0);
    chk("rw_no_we", 32'(we_cnt - we0), 32'd0);

    // Reset during RD_DRIVE drops db_oe without waiting for a clock
    lat = 1;
    ma = 8'h01; nmrd = 1'b0;
    repeat (12) @(negedge clk);
    chk("rd_drive_oe", 32'(db_oe), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rd_async_oe", 32'(db_oe), 32'd0);
    chk("rd_async_dbout", 32'(db_out), 32'd0);
    nmrd = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("never_rd_and_we", 32'(both_seen), 32'd0);
    chk("final_no_we", 32'(we_cnt - we0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
